// File: rtl/i2c_arb.sv
// ----------------------------------------------------------------------------
// i2c_arb
// Two-requester round-robin arbiter in front of a single I2C EEPROM driver.
// A winner's command is registered onto the drv_* outputs. A one-cycle
// drv_exec pulse starts the driver. The driver's response, or a timeout
// abort, is returned to the winner as a one-cycle done pulse.
//
// Parameters
//   TIMEOUT_CYC : number of cycles to wait for drv_done before aborting
//   TO_W        : timeout counter width, 2**TO_W > TIMEOUT_CYC
//
// Ports
//   clk, rst                 : driver clock, synchronous active-high reset
//   req0/1, rh_wl0/1         : request and direction (1 = read, 0 = write)
//   addr0/1, data_w0/1       : EEPROM word address and write data
//   gnt0/1                   : requester owns the driver
//   done0/1                  : one-cycle completion pulse
//   data_r0/1, ack0/1, err0/1: read data, NACK-or-timeout, timeout flag;
//                              all valid with done
//   drv_exec, drv_rh_wl,
//   drv_addr, drv_data_w     : command to the driver
//   drv_done, drv_ack,
//   drv_data_r               : response from the driver
// ----------------------------------------------------------------------------
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate among pending requests
// ST_ISSUE | drv_exec high for this cycle; timeout counter cleared
// ST_WAIT  | wait for drv_done or for the timeout to expire
// ST_RESP  | done pulse to the owner; gnt drops at the end of the cycle
// ST_GUARD | one dead cycle; requests are ignored
// ----------------------------------------------------------------------------
module i2c_arb #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd200_000,
    parameter int unsigned TO_W        = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rh_wl0,
    input  logic        rh_wl1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  data_w0,
    input  logic [7:0]  data_w1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  data_r0,
    output logic [7:0]  data_r1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic        drv_exec,
    output logic        drv_rh_wl,
    output logic [15:0] drv_addr,
    output logic [7:0]  drv_data_w,
    input  logic        drv_done,
    input  logic        drv_ack,
    input  logic [7:0]  drv_data_r
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_GUARD
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 20'd1);

    state_t          state, state_nx;
    logic            last_grant, last_grant_nx;
    logic            sel, sel_nx;
    logic [TO_W-1:0] cnt, cnt_nx;

    logic            gnt0_nx, gnt1_nx, done0_nx, done1_nx;
    logic [7:0]      data_r0_nx, data_r1_nx;
    logic            ack0_nx, ack1_nx, err0_nx, err1_nx;
    logic            drv_exec_nx, drv_rh_wl_nx;
    logic [15:0]     drv_addr_nx;
    logic [7:0]      drv_data_w_nx;

    logic            win;
    logic            rsp_fire, rsp_ack, rsp_err;
    logic [7:0]      rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            cnt        <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            data_r0    <= 8'h00;
            data_r1    <= 8'h00;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            drv_exec   <= 1'b0;
            drv_rh_wl  <= 1'b0;
            drv_addr   <= 16'h0000;
            drv_data_w <= 8'h00;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            sel        <= sel_nx;
            cnt        <= cnt_nx;
            gnt0       <= gnt0_nx;
            gnt1       <= gnt1_nx;
            done0      <= done0_nx;
            done1      <= done1_nx;
            data_r0    <= data_r0_nx;
            data_r1    <= data_r1_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            err0       <= err0_nx;
            err1       <= err1_nx;
            drv_exec   <= drv_exec_nx;
            drv_rh_wl  <= drv_rh_wl_nx;
            drv_addr   <= drv_addr_nx;
            drv_data_w <= drv_data_w_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        sel_nx        = sel;
        cnt_nx        = cnt;
        gnt0_nx       = gnt0;
        gnt1_nx       = gnt1;
        drv_rh_wl_nx  = drv_rh_wl;
        drv_addr_nx   = drv_addr;
        drv_data_w_nx = drv_data_w;
        // Pulsed / response outputs are zero outside the cycle they are set for.
        drv_exec_nx   = 1'b0;
        done0_nx      = 1'b0;
        done1_nx      = 1'b0;
        data_r0_nx    = 8'h00;
        data_r1_nx    = 8'h00;
        ack0_nx       = 1'b0;
        ack1_nx       = 1'b0;
        err0_nx       = 1'b0;
        err1_nx       = 1'b0;
        win           = 1'b0;
        rsp_fire      = 1'b0;
        rsp_ack       = 1'b0;
        rsp_err       = 1'b0;
        rsp_data      = 8'h00;

        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to the requester that did not win last time.
                    win           = (req0 && req1) ? ~last_grant : req1;
                    sel_nx        = win;
                    last_grant_nx = win;
                    gnt0_nx       = ~win;
                    gnt1_nx       = win;
                    drv_exec_nx   = 1'b1;
                    drv_rh_wl_nx  = win ? rh_wl1  : rh_wl0;
                    drv_addr_nx   = win ? addr1   : addr0;
                    drv_data_w_nx = win ? data_w1 : data_w0;
                    state_nx      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_nx   = '0;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // drv_done wins over an expiring timeout in the same cycle.
                if (drv_done) begin
                    rsp_fire = 1'b1;
                    rsp_ack  = drv_ack;
                    rsp_data = drv_data_r;
                end else if (cnt == TO_LAST) begin
                    rsp_fire = 1'b1;
                    rsp_ack  = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_nx = cnt + TO_W'(1);
                end
            end
            ST_RESP: begin
                gnt0_nx  = 1'b0;
                gnt1_nx  = 1'b0;
                state_nx = ST_GUARD;
            end
            ST_GUARD: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (rsp_fire) begin
            state_nx = ST_RESP;
            if (sel) begin
                done1_nx   = 1'b1;
                data_r1_nx = rsp_data;
                ack1_nx    = rsp_ack;
                err1_nx    = rsp_err;
            end else begin
                done0_nx   = 1'b1;
                data_r0_nx = rsp_data;
                ack0_nx    = rsp_ack;
                err0_nx    = rsp_err;
            end
        end
    end

endmodule

// File: doc/i2c_arb.md
I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20'd200_000, is the number of clk cycles the block waits for drv_done before aborting.
REQ-002 Parameter TO_W, default 18, is the width of the timeout counter and SHALL satisfy 2^TO_W > TIMEOUT_CYC.
REQ-003 Port clk, input, 1: the single clock; it SHALL be the I2C driver's drv_clk.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports req0/req1, input, 1 each: transaction request from requester 0/1.
REQ-006 Ports rh_wl0/rh_wl1, input, 1 each: 1 = read, 0 = write.
REQ-007 Ports addr0/addr1, input, 16 each: EEPROM word address.
REQ-008 Ports data_w0/data_w1, input, 8 each: write data.
REQ-009 Ports gnt0/gnt1, output, 1 each: requester owns the driver.
REQ-010 Ports done0/done1, output, 1 each: one-cycle completion pulse.
REQ-011 Ports data_r0/data_r1, output, 8 each: read data, valid while done is high.
REQ-012 Ports ack0/ack1, output, 1 each: 1 = slave NACK or timeout, valid while done is high.
REQ-013 Ports err0/err1, output, 1 each: 1 = timeout abort, valid while done is high.
REQ-014 Ports drv_exec (output, 1), drv_rh_wl (output, 1), drv_addr (output, 16) and drv_data_w (output, 8) form the command to the I2C driver.
REQ-015 Ports drv_done (input, 1), drv_ack (input, 1) and drv_data_r (input, 8) carry the response from the I2C driver.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, RESP and GUARD, plus a last_grant register (1 bit).
REQ-017 In IDLE, if any req is high, the block SHALL select a winner by round-robin: the requester other than last_grant wins a tie, and a sole requester always wins.
REQ-018 On selection, the block SHALL register the winner's rh_wl, addr and data_w onto drv_rh_wl, drv_addr and drv_data_w, set gnt of the winner, set last_grant to the winner, and go to ISSUE.
REQ-019 In ISSUE, drv_exec SHALL be high for exactly one cycle, the timeout counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-020 drv_exec SHALL never be high in any state other than ISSUE.
REQ-021 The drv_* command outputs SHALL hold stable from ISSUE until the FSM leaves RESP.
REQ-022 In WAIT, on drv_done=1 the block SHALL capture drv_ack and drv_data_r, clear err, and go to RESP.
REQ-023 drv_done SHALL be ignored in every state other than WAIT.
REQ-024 In WAIT, the counter SHALL increment each cycle without drv_done.
REQ-025 When the counter reaches TIMEOUT_CYC-1 without drv_done, the block SHALL set ack=1, err=1 and data_r=0, and go to RESP.
REQ-026 If drv_done arrives in the same cycle the counter reaches TIMEOUT_CYC-1, drv_done SHALL take priority and no error is flagged.
REQ-027 In RESP, done of the granted requester SHALL pulse for one cycle with data_r, ack and err valid; the outputs of the non-granted requester SHALL stay 0.
REQ-028 In RESP, gnt SHALL drop at the end of the cycle and the FSM SHALL go to GUARD.
REQ-029 GUARD SHALL last one cycle, ignore all req inputs, and then return to IDLE.
REQ-030 A requester SHALL deassert req within one cycle of seeing done.
REQ-031 A req still high in IDLE after GUARD SHALL be treated as a new request.
REQ-032 Deassertion of the granted requester's req before done SHALL NOT abort the transaction; done SHALL still pulse.
REQ-033 Changes to the request inputs while granted SHALL NOT alter the drv_* outputs.
REQ-034 Latency: req sampled high in IDLE at edge k gives gnt=1 from k+1, drv_exec=1 in cycle k+1 only, and done=1 one cycle after the drv_done cycle.
REQ-035 gnt0 and gnt1 SHALL never both be high, and done0 and done1 SHALL never both be high.

Reset
REQ-036 When rst=1 at a clk edge, the FSM SHALL go to IDLE, last_grant SHALL become 1, the counter SHALL become 0, and every output SHALL become 0.
REQ-037 Reset mid-transaction SHALL drop gnt and produce no done pulse; drv_done arriving after reset SHALL be ignored.

Verification
REQ-038 Single read: req0=1, rh_wl0=1, addr0=16'h0010; driver returns ack=0, data=8'hA5 -> one drv_exec pulse with drv_addr=16'h0010; done0=1 for one cycle, data_r0=8'hA5, ack0=0, err0=0.
REQ-039 Simultaneous requests: req0=req1=1 after reset -> requester 0 is served first, then requester 1 after GUARD; this is exactly two drv_exec pulses, in order.
REQ-040 Fairness: req0 and req1 are held high continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-041 Timeout: set TIMEOUT_CYC=16 and never assert drv_done -> done1 pulses 16 cycles after WAIT entry with ack1=1, err1=1, data_r1=0.
REQ-042 NACK: drv_ack=1 on drv_done -> the granted requester's ack=1 and err=0.
REQ-043 Reset in WAIT, with drv_done 2 cycles later -> no done pulse, all outputs stay 0, and the next req is granted normally.
